pwm_voice_bank: RTL and testbench

- Consumer side of the core's eight PWM registers (pwm_reg0..7). The core writes these registers; this block reads them.
- Eight square-wave tone voices, one per register.
- The voices are mixed into a 6-bit amplitude, which drives a 1-bit PWM audio DAC output.
- Sits between the core's register file outputs and the board audio pin.

---
 rtl/pwm_pkg.sv | 17 +
 rtl/pwm_voice_bank_if.sv | 37 +++
 rtl/pwm_voice.sv | 54 +++++
 rtl/pwm_voice_bank.sv | 89 ++++++++
 tb/tb_pwm_voice_bank.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/pwm_pkg.sv
// Shared field layout and widths for the PWM voice bank.
// Control word: [15] enable, [14:12] volume, [11:0] half-period.
package pwm_pkg;

  localparam int NUM_VOICES = 8;
  localparam int CTRL_W     = 16;

  localparam int EN_BIT  = 15;
  localparam int VOL_MSB = 14;
  localparam int VOL_LSB = 12;
  localparam int PER_MSB = 11;

  localparam int VOL_W = 3;
  localparam int PER_W = 12;
  localparam int MIX_W = 6;

endpackage

// File: rtl/pwm_voice_bank_if.sv
// Register-file side and audio side of the voice bank.
// The core (master) drives the control words; the bank (slave) drives audio.
interface pwm_voice_bank_if;

  logic [15:0] pwm_reg0;
  logic [15:0] pwm_reg1;
  logic [15:0] pwm_reg2;
  logic [15:0] pwm_reg3;
  logic [15:0] pwm_reg4;
  logic [15:0] pwm_reg5;
  logic [15:0] pwm_reg6;
  logic [15:0] pwm_reg7;

  logic        audio_out;
  logic [5:0]  sample;
  logic        sample_valid;
  logic [7:0]  voice_phase;

  modport master (
    output pwm_reg0, pwm_reg1,
    output pwm_reg2, pwm_reg3,
    output pwm_reg4, pwm_reg5,
    output pwm_reg6, pwm_reg7,
    input  audio_out, sample,
    input  sample_valid, voice_phase
  );

  modport slave (
    input  pwm_reg0, pwm_reg1,
    input  pwm_reg2, pwm_reg3,
    input  pwm_reg4, pwm_reg5,
    input  pwm_reg6, pwm_reg7,
    output audio_out, sample,
    output sample_valid, voice_phase
  );

endinterface

// File: rtl/pwm_voice.sv
// One square-wave voice: shadowed control word, tick counter, phase bit.
// Shadow reloads only at half-period boundaries so retunes are glitch-free.
module pwm_voice
  import pwm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic [CTRL_W-1:0] ctrl,
  output logic              phase,
  output logic [VOL_W-1:0]  vol
);

  logic             live_en;
  logic [VOL_W-1:0] live_vol;
  logic [PER_W-1:0] live_per;

  logic [VOL_W-1:0] shadow_vol;
  logic [PER_W-1:0] shadow_per;
  logic [PER_W-1:0] cnt;
  logic             boundary;

  assign live_en  = ctrl[EN_BIT];
  assign live_vol = ctrl[VOL_MSB:VOL_LSB];
  assign live_per = ctrl[PER_MSB:0];

  assign boundary = (cnt == shadow_per - PER_W'(1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      shadow_vol <= '0;
      shadow_per <= '0;
      cnt        <= '0;
      phase      <= 1'b0;
    end else if (!live_en || shadow_per == '0) begin
      shadow_vol <= live_vol;
      shadow_per <= live_per;
      cnt        <= '0;
      phase      <= 1'b0;
    end else if (tick) begin
      if (boundary) begin
        cnt        <= '0;
        phase      <= ~phase;
        shadow_vol <= live_vol;
        shadow_per <= live_per;
      end else begin
        cnt <= cnt + PER_W'(1);
      end
    end
  end

  assign vol = shadow_vol;

endmodule

// File: rtl/pwm_voice_bank.sv
// Eight tone voices mixed to a 6-bit amplitude and sent out as 1-bit PWM.
// Sample is latched only at carrier wrap, so each carrier period is whole.
module pwm_voice_bank
  import pwm_pkg::*;
#(
  parameter int CLK_DIV     = 50,
  parameter int CARRIER_MAX = 62
) (
  input  logic clk,
  input  logic rst,
  pwm_voice_bank_if.slave bus
);

  logic [15:0]       div_cnt;
  logic              tick;

  logic [CTRL_W-1:0] ctrl [NUM_VOICES];
  logic [VOL_W-1:0]  vol  [NUM_VOICES];
  logic [NUM_VOICES-1:0] phase;

  logic [MIX_W-1:0]  mix;
  logic [MIX_W-1:0]  carrier;
  logic              wrap;
  logic [MIX_W-1:0]  sample_r;
  logic              valid_r;
  logic              audio_r;

  assign tick = (div_cnt == 16'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 16'd1;
    end
  end

  assign ctrl[0] = bus.pwm_reg0;
  assign ctrl[1] = bus.pwm_reg1;
  assign ctrl[2] = bus.pwm_reg2;
  assign ctrl[3] = bus.pwm_reg3;
  assign ctrl[4] = bus.pwm_reg4;
  assign ctrl[5] = bus.pwm_reg5;
  assign ctrl[6] = bus.pwm_reg6;
  assign ctrl[7] = bus.pwm_reg7;

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
    pwm_voice u_voice (
      .clk   (clk),
      .rst   (rst),
      .tick  (tick),
      .ctrl  (ctrl[g]),
      .phase (phase[g]),
      .vol   (vol[g])
    );
  end

  // 8 x 7 = 56 fits in 6 bits, no saturation needed
  always_comb begin
    mix = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (phase[i]) mix = mix + MIX_W'(vol[i]);
    end
  end

  assign wrap = (carrier == MIX_W'(CARRIER_MAX));

  always_ff @(posedge clk) begin
    if (!rst) begin
      carrier  <= '0;
      sample_r <= '0;
      valid_r  <= 1'b0;
      audio_r  <= 1'b0;
    end else begin
      carrier  <= wrap ? '0 : carrier + MIX_W'(1);
      valid_r  <= wrap;
      audio_r  <= (carrier < sample_r);
      if (wrap) sample_r <= mix;
    end
  end

  assign bus.sample       = sample_r;
  assign bus.sample_valid = valid_r;
  assign bus.audio_out    = audio_r;
  assign bus.voice_phase  = phase;

endmodule

// File: tb/tb_pwm_voice_bank.sv
// Self-checking bench for pwm_voice_bank with CLK_DIV = 4.
// Vector table plus directed sequences for retune, disable and reset.
module tb_pwm_voice_bank;

  logic clk = 1'b0;
  logic rst = 1'b0;

  pwm_voice_bank_if bus();

  pwm_voice_bank #(
    .CLK_DIV     (4),
    .CARRIER_MAX (62)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int sb[$];

  typedef struct {
    logic [7:0]  mask;
    logic [15:0] word;
    int          half;
    int          on;
  } vec_t;

  vec_t vecs[6];

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d",
               name, cyc, act, exp);
    end
  endfunction

  function automatic int outs();
    return int'({bus.audio_out, bus.sample,
                 bus.sample_valid, bus.voice_phase});
  endfunction

  function automatic int exp_sample(int k, int half, int on);
    if (half == 0) return 0;
    return ((((63 * k) - 1) / half) % 2 != 0) ? on : 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_regs(logic [7:0] mask, logic [15:0] w);
    bus.pwm_reg0 = mask[0] ? w : 16'h0;
    bus.pwm_reg1 = mask[1] ? w : 16'h0;
    bus.pwm_reg2 = mask[2] ? w : 16'h0;
    bus.pwm_reg3 = mask[3] ? w : 16'h0;
    bus.pwm_reg4 = mask[4] ? w : 16'h0;
    bus.pwm_reg5 = mask[5] ? w : 16'h0;
    bus.pwm_reg6 = mask[6] ? w : 16'h0;
    bus.pwm_reg7 = mask[7] ? w : 16'h0;
  endtask

  task automatic do_reset(int n);
    rst = 1'b0;
    repeat (n) step();
    rst = 1'b1;
    cyc = 0;
  endtask

  task automatic run_vec(vec_t v);
    int k = 0;
    int hi = 0;
    int prev = 0;
    int exp_ph;
    int e;
    set_regs(v.mask, v.word);
    do_reset(2);
    sb.delete();
    sb.push_back(exp_sample(1, v.half, v.on));
    repeat (4 * 63) begin
      step();
      exp_ph = 0;
      if (v.half != 0 && ((cyc / v.half) % 2) != 0)
        exp_ph = int'(v.mask);
      check("phase", int'(bus.voice_phase), exp_ph);
      hi += int'(bus.audio_out);
      if (bus.sample_valid) begin
        k++;
        check("valid_time", cyc, 63 * k);
        e = sb.pop_front();
        check("sample", int'(bus.sample), e);
        check("duty", hi, prev);
        hi = 0;
        prev = e;
        sb.push_back(exp_sample(k + 1, v.half, v.on));
      end else begin
        check("sample_hold", int'(bus.sample), prev);
      end
    end
    check("wraps", k, 4);
  endtask

  initial begin
    int tog[$];
    int exp_tog[4];
    logic ph;

    vecs[0] = '{8'h01, 16'hF003, 12, 7};
    vecs[1] = '{8'hFF, 16'hF001, 4, 56};
    vecs[2] = '{8'h0F, 16'hA005, 20, 8};
    vecs[3] = '{8'h80, 16'h9002, 8, 1};
    vecs[4] = '{8'h01, 16'h8003, 12, 0};
    vecs[5] = '{8'h01, 16'h7003, 0, 0};

    // reset held with all voices configured
    set_regs(8'hFF, 16'hF001);
    rst = 1'b0;
    repeat (5) begin
      step();
      check("reset_outs", outs(), 0);
    end
    rst = 1'b1;
    cyc = 0;
    step();
    check("post_reset_outs", outs(), 0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // retune from per 10 to per 2 at count 6
    set_regs(8'h01, 16'hF00A);
    do_reset(2);
    repeat (24) step();
    check("retune_pre", int'(bus.voice_phase[0]), 0);
    bus.pwm_reg0 = 16'hF002;
    exp_tog = '{40, 48, 56, 64};
    ph = 1'b0;
    repeat (46) begin
      step();
      if (bus.voice_phase[0] != ph) tog.push_back(cyc);
      ph = bus.voice_phase[0];
    end
    check("retune_count", tog.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < tog.size())
        check("retune_edge", tog[i], exp_tog[i]);
    end

    // disable an active voice while sample = 7
    set_regs(8'h01, 16'hF003);
    do_reset(2);
    repeat (63) step();
    check("dis_valid", int'(bus.sample_valid), 1);
    check("dis_sample", int'(bus.sample), 7);
    check("dis_phase_hi", int'(bus.voice_phase[0]), 1);
    bus.pwm_reg0 = 16'h7003;
    sb.delete();
    sb.push_back(0);
    step();
    check("dis_phase_lo", int'(bus.voice_phase[0]), 0);
    repeat (61) step();
    check("dis_hold", int'(bus.sample), 7);
    step();
    check("dis_valid2", int'(bus.sample_valid), 1);
    check("dis_drop", int'(bus.sample), sb.pop_front());

    // enabled with zero period stays silent
    bus.pwm_reg0 = 16'h7000;
    step();
    bus.pwm_reg0 = 16'hF000;
    repeat (40) begin
      step();
      check("per0_phase", int'(bus.voice_phase[0]), 0);
    end

    // reset mid-tone, then restart timing
    set_regs(8'h01, 16'hF003);
    do_reset(2);
    repeat (63) step();
    check("mid_phase", int'(bus.voice_phase[0]), 1);
    check("mid_sample", int'(bus.sample), 7);
    rst = 1'b0;
    step();
    check("mid_reset_outs", outs(), 0);
    rst = 1'b1;
    cyc = 0;
    repeat (13) begin
      step();
      check("restart_phase", int'(bus.voice_phase[0]),
            (cyc >= 12) ? 1 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
